// File: rtl/conv_ch_serializer.sv
// ---------------------------------------------------------------------------
// conv_ch_serializer
//
// Sits behind a multi-filter conv layer. One frame of NUM_CH parallel channel
// streams is captured into per-channel buffers, then replayed channel by
// channel as a single 32-bit stream for a next layer that only takes one d_in.
// The output side is push-only. Downstream readiness is looked at once, just
// before each channel is replayed.
//
// Parameters
//   NUM_CH      number of parallel input channels
//   OUT_W/OUT_H frame geometry; FRAME = OUT_W*OUT_H words per channel
//   GAP_CYCLES  idle cycles inserted between replayed channels (may be 0)
//
// Ports
//   clk         clock
//   rst         asynchronous, active-low reset
//   i_sof       start of frame, qualified by i_valid
//   i_valid     input word valid (all channels together)
//   i_data      one 32-bit word per channel
//   ds_ready    downstream ready, sampled before each channel replay
//   o_sof       high with o_valid on the first word of each channel
//   o_valid     output word valid
//   o_data      output word (holds its last value while o_valid is low)
//   o_ch        channel index of the current output word
//   frame_done  one-cycle pulse in the cycle after the last output word
//   overrun     sticky flag: an i_sof arrived while the frame was not
//               being captured and was dropped; cleared only by reset
//   busy        high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module conv_ch_serializer #(
  parameter  int NUM_CH     = 4,
  parameter  int OUT_W      = 32,
  parameter  int OUT_H      = 32,
  parameter  int GAP_CYCLES = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_sof,
  input  logic            i_valid,
  input  logic [31:0]     i_data [NUM_CH],
  input  logic            ds_ready,
  output logic            o_sof,
  output logic            o_valid,
  output logic [31:0]     o_data,
  output logic [CH_W-1:0] o_ch,
  output logic            frame_done,
  output logic            overrun,
  output logic            busy
);

  localparam int FRAME = OUT_W * OUT_H;
  localparam int AW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  // The gap counter runs 0..GAP_CYCLES-1.
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [AW-1:0]   LAST_ADDR = AW'(FRAME - 1);
  localparam logic [GW-1:0]   GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT_RDY,
    REPLAY,
    GAP,
    DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;
  logic [GW-1:0]   gap_cnt;
  logic [CH_W-1:0] ch;

  // First pipeline stage of the replay path. It runs alongside the
  // synchronous buffer read and carries the word's sideband information.
  logic            pipe_valid;
  logic            pipe_sof;
  logic [CH_W-1:0] pipe_ch;

  logic [31:0]     rd_word [NUM_CH];

  logic            wr_en;
  logic [AW-1:0]   wr_a;
  logic            rd_en;

  // A frame may begin only from IDLE. Inside CAPTURE, any valid word is
  // written. A repeated i_sof restarts the frame at address 0.
  assign wr_en = i_valid && (((state == IDLE) && i_sof) || (state == CAPTURE));
  assign wr_a  = i_sof ? '0 : wr_addr;
  assign rd_en = (state == REPLAY);

  assign busy  = (state != IDLE);

  // Per-channel frame buffers. Every channel is written with the same
  // address on the same cycle. Each buffer has a registered read port, so
  // the word is available one cycle after rd_addr is presented.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_buf
    logic [31:0] mem [FRAME];
    logic [31:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[wr_a] <= i_data[c];
      end
      if (rd_en) begin
        rd_q <= mem[rd_addr];
      end
    end

    assign rd_word[c] = rd_q;
  end

  // Main control FSM and registered outputs.
  // Replay timing: the edge that sees ds_ready moves the FSM to REPLAY with
  // rd_addr=0. The next edge reads the buffer and loads the pipe stage. The
  // edge after that drives o_valid/o_data. DONE waits until the pipe stage
  // is empty, which makes frame_done land in the cycle right after the last
  // o_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_addr    <= '0;
      rd_addr    <= '0;
      gap_cnt    <= '0;
      ch         <= '0;
      pipe_valid <= 1'b0;
      pipe_sof   <= 1'b0;
      pipe_ch    <= '0;
      o_sof      <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_ch       <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pipe_valid <= 1'b0;
      frame_done <= 1'b0;

      o_valid    <= pipe_valid;
      o_sof      <= pipe_valid & pipe_sof;
      if (pipe_valid) begin
        o_data <= rd_word[pipe_ch];
        o_ch   <= pipe_ch;
      end

      // No capture is possible until the stored frame has been replayed.
      if (i_valid && i_sof && (state inside {WAIT_RDY, REPLAY, GAP, DONE})) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (i_valid && i_sof) begin
            wr_addr <= AW'(1);
            state   <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (i_valid) begin
            if (i_sof) begin
              wr_addr <= AW'(1);
            end else if (wr_addr == LAST_ADDR) begin
              wr_addr <= '0;
              ch      <= '0;
              state   <= WAIT_RDY;
            end else begin
              wr_addr <= wr_addr + AW'(1);
            end
          end
        end

        WAIT_RDY: begin
          if (ds_ready) begin
            rd_addr <= '0;
            state   <= REPLAY;
          end
        end

        REPLAY: begin
          pipe_valid <= 1'b1;
          pipe_sof   <= (rd_addr == '0);
          pipe_ch    <= ch;
          if (rd_addr == LAST_ADDR) begin
            rd_addr <= '0;
            if (ch == LAST_CH) begin
              state <= DONE;
            end else if (GAP_CYCLES == 0) begin
              ch    <= ch + CH_W'(1);
              state <= WAIT_RDY;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            ch      <= ch + CH_W'(1);
            state   <= WAIT_RDY;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        DONE: begin
          if (!pipe_valid) begin
            frame_done <= 1'b1;
            ch         <= '0;
            state      <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ch_serializer.sv
// ---------------------------------------------------------------------------
// tb_conv_ch_serializer
//
// Self-checking bench for conv_ch_serializer with NUM_CH=4, FRAME=8 (4x2),
// GAP_CYCLES=2. Every input beat of a scenario is kept in a list. The
// expected output stream comes from the frame rules alone:
//   - a frame starts at a valid i_sof;
//   - every valid word after that is appended, and a new i_sof restarts;
//   - once FRAME words are held, the frame is emitted channel-major.
// A monitor records every o_valid word and frame_done pulse with its cycle
// number. Each scenario task compares those records against the model.
// ---------------------------------------------------------------------------
module tb_conv_ch_serializer;

  localparam int NUM_CH = 4;
  localparam int OUT_W  = 4;
  localparam int OUT_H  = 2;
  localparam int GAP    = 2;
  localparam int FRAME  = OUT_W * OUT_H;
  localparam int TOTAL  = FRAME * NUM_CH;

  typedef struct packed {
    logic                   v;
    logic                   s;
    logic [NUM_CH-1:0][31:0] d;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        i_sof;
  logic        i_valid;
  logic [31:0] i_data [NUM_CH];
  logic        ds_ready;
  logic        o_sof;
  logic        o_valid;
  logic [31:0] o_data;
  logic [1:0]  o_ch;
  logic        frame_done;
  logic        overrun;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  beat_t       stim[$];
  logic [31:0] exp_q[$];
  logic [31:0] mon_data[$];
  int          mon_ch[$];
  bit          mon_sof[$];
  int          mon_t[$];
  int          done_t[$];

  conv_ch_serializer #(
    .NUM_CH    (NUM_CH),
    .OUT_W     (OUT_W),
    .OUT_H     (OUT_H),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_sof     (i_sof),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .ds_ready  (ds_ready),
    .o_sof     (o_sof),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_ch      (o_ch),
    .frame_done(frame_done),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the output stream on the falling edge, away from the edge where
  // outputs change.
  always @(negedge clk) begin
    if (o_valid) begin
      mon_data.push_back(o_data);
      mon_ch.push_back(int'(o_ch));
      mon_sof.push_back(o_sof);
      mon_t.push_back(cyc);
    end
    if (frame_done) done_t.push_back(cyc);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no $finish within time limit, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [NUM_CH-1:0][31:0] basic_word(input int k);
    logic [NUM_CH-1:0][31:0] w;
    for (int c = 0; c < NUM_CH; c++) w[c] = 32'h100 * c + k;
    return w;
  endfunction

  function automatic logic [NUM_CH-1:0][31:0] rand_word();
    logic [NUM_CH-1:0][31:0] w;
    for (int c = 0; c < NUM_CH; c++) w[c] = $urandom;
    return w;
  endfunction

  task automatic add_beat(input logic v, input logic s, input logic [NUM_CH-1:0][31:0] d);
    beat_t b;
    b.v = v;
    b.s = s;
    b.d = d;
    stim.push_back(b);
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_ch.delete();
    mon_sof.delete();
    mon_t.delete();
    done_t.delete();
  endtask

  // Apply the frame rules to the beat list and build the expected stream.
  task automatic build_expected();
    logic [NUM_CH-1:0][31:0] words[$];
    bit active = 1'b0;
    exp_q.delete();
    for (int i = 0; i < stim.size(); i++) begin
      if (words.size() == FRAME) break;
      if (stim[i].v && stim[i].s) begin
        words.delete();
        active = 1'b1;
      end
      if (stim[i].v && active) words.push_back(stim[i].d);
    end
    if (words.size() == FRAME)
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < FRAME; k++)
          exp_q.push_back(words[k][c]);
  endtask

  task automatic drive_stim();
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk);
      i_valid = stim[i].v;
      i_sof   = stim[i].s;
      for (int c = 0; c < NUM_CH; c++) i_data[c] = stim[i].d[c];
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = (done_t.size() != 0);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_valid, o_sof, o_data, o_ch, frame_done, overrun, busy} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_held: got v=%b sof=%b data=%h ch=%0d done=%b ovr=%b busy=%b, required all 0",
               o_valid, o_sof, o_data, o_ch, frame_done, overrun, busy);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_valid, o_sof, o_data, o_ch, frame_done, overrun, busy} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_release: got v=%b sof=%b data=%h ch=%0d done=%b ovr=%b busy=%b, required all 0",
               o_valid, o_sof, o_data, o_ch, frame_done, overrun, busy);
    end
    // A valid word without i_sof must not start a capture.
    i_valid = 1'b1;
    for (int c = 0; c < NUM_CH; c++) i_data[c] = $urandom;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL idle_stray_valid: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_mon();
    stim.delete();
    ds_ready = 1'b1;
    for (int k = 0; k < FRAME; k++) add_beat(1'b1, k == 0, basic_word(k));
    build_expected();
    drive_stim();
    wait_done(1000, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("[TB] FAIL basic_done: got no frame_done, required 1 pulse"); end
    n_cmp++;
    if (mon_data.size() != TOTAL) begin
      n_bad++; $display("[TB] FAIL basic_count: got %0d words, required %0d", mon_data.size(), TOTAL);
    end
    for (int i = 0; i < TOTAL && i < mon_data.size(); i++) begin
      n_cmp++;
      if (mon_data[i] !== exp_q[i] || mon_ch[i] != i / FRAME || mon_sof[i] != (i % FRAME == 0)) begin
        n_bad++;
        $display("[TB] FAIL basic_word%0d: got data=%h ch=%0d sof=%0b, required data=%h ch=%0d sof=%0b",
                 i, mon_data[i], mon_ch[i], mon_sof[i], exp_q[i], i / FRAME, i % FRAME == 0);
      end
      if (i > 0) begin
        n_cmp++;
        if ((i % FRAME != 0) ? (mon_t[i] - mon_t[i-1] != 1) : (mon_t[i] - mon_t[i-1] < GAP + 2)) begin
          n_bad++;
          $display("[TB] FAIL basic_spacing%0d: got %0d cycles from previous word, required %0d%s",
                   i, mon_t[i] - mon_t[i-1], (i % FRAME != 0) ? 1 : GAP + 2, (i % FRAME != 0) ? "" : " or more");
        end
      end
    end
    n_cmp++;
    if (done_t.size() != 1 || mon_t.size() == 0 || done_t[0] != mon_t[mon_t.size()-1] + 1) begin
      n_bad++;
      $display("[TB] FAIL basic_done_timing: got %0d pulses (first at %0d), required 1 pulse at %0d",
               done_t.size(), (done_t.size() != 0) ? done_t[0] : -1,
               (mon_t.size() != 0) ? mon_t[mon_t.size()-1] + 1 : -1);
    end
    n_cmp++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      n_bad++; $display("[TB] FAIL basic_idle: got busy=%b overrun=%b, required 0 0", busy, overrun);
    end
  endtask

  task automatic test_gapped();
    bit ok;
    clear_mon();
    stim.delete();
    ds_ready = 1'b1;
    for (int j = 0; j < 3; j++) add_beat(1'b1, 1'b0, rand_word());
    for (int k = 0; k < FRAME; k++) begin
      add_beat(1'b1, k == 0, basic_word(k));
      add_beat(1'b0, 1'($urandom_range(0, 1)), rand_word());
    end
    build_expected();
    drive_stim();
    wait_done(1000, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("[TB] FAIL gapped_done: got no frame_done, required 1 pulse"); end
    n_cmp++;
    if (mon_data.size() != TOTAL) begin
      n_bad++; $display("[TB] FAIL gapped_count: got %0d words, required %0d", mon_data.size(), TOTAL);
    end
    for (int i = 0; i < TOTAL && i < mon_data.size(); i++) begin
      n_cmp++;
      if (mon_data[i] !== exp_q[i] || mon_ch[i] != i / FRAME || mon_sof[i] != (i % FRAME == 0)) begin
        n_bad++;
        $display("[TB] FAIL gapped_word%0d: got data=%h ch=%0d sof=%0b, required data=%h ch=%0d sof=%0b",
                 i, mon_data[i], mon_ch[i], mon_sof[i], exp_q[i], i / FRAME, i % FRAME == 0);
      end
    end
    n_cmp++;
    if (done_t.size() != 1) begin
      n_bad++; $display("[TB] FAIL gapped_pulses: got %0d frame_done pulses, required 1", done_t.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int r;
    clear_mon();
    stim.delete();
    ds_ready = 1'b0;
    for (int k = 0; k < FRAME; k++) add_beat(1'b1, k == 0, rand_word());
    build_expected();
    drive_stim();
    repeat (20) @(negedge clk);
    n_cmp++;
    if (mon_data.size() != 0 || busy !== 1'b1) begin
      n_bad++; $display("[TB] FAIL bp_hold: got %0d words busy=%b, required 0 words busy=1", mon_data.size(), busy);
    end
    // ds_ready is sampled at the next rising edge; the first word is
    // registered two edges after that.
    ds_ready = 1'b1;
    r = cyc;
    for (int n = 0; n < 50 && mon_data.size() == 0; n++) @(negedge clk);
    n_cmp++;
    if (mon_data.size() == 0 || mon_t[0] != r + 3) begin
      n_bad++;
      $display("[TB] FAIL bp_latency: got first word at cycle %0d, required %0d",
               (mon_t.size() != 0) ? mon_t[0] : -1, r + 3);
    end
    // Withdraw readiness once channel 1 has finished, before channel 2.
    for (int n = 0; n < 200 && mon_data.size() < 2 * FRAME; n++) @(negedge clk);
    ds_ready = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (mon_data.size() != 2 * FRAME || busy !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL bp_stall: got %0d words busy=%b, required %0d words busy=1", mon_data.size(), busy, 2 * FRAME);
    end
    ds_ready = 1'b1;
    r = cyc;
    for (int n = 0; n < 50 && mon_data.size() <= 2 * FRAME; n++) @(negedge clk);
    n_cmp++;
    if (mon_data.size() <= 2 * FRAME || mon_t[2 * FRAME] != r + 3) begin
      n_bad++;
      $display("[TB] FAIL bp_ch2_latency: got ch2 start at cycle %0d, required %0d",
               (mon_t.size() > 2 * FRAME) ? mon_t[2 * FRAME] : -1, r + 3);
    end
    wait_done(1000, ok);
    n_cmp++;
    if (!ok || done_t.size() != 1) begin
      n_bad++; $display("[TB] FAIL bp_done: got %0d frame_done pulses, required 1", done_t.size());
    end
    n_cmp++;
    if (mon_data.size() != TOTAL) begin
      n_bad++; $display("[TB] FAIL bp_count: got %0d words, required %0d", mon_data.size(), TOTAL);
    end
    for (int i = 0; i < TOTAL && i < mon_data.size(); i++) begin
      n_cmp++;
      if (mon_data[i] !== exp_q[i] || mon_ch[i] != i / FRAME || mon_sof[i] != (i % FRAME == 0)) begin
        n_bad++;
        $display("[TB] FAIL bp_word%0d: got data=%h ch=%0d sof=%0b, required data=%h ch=%0d sof=%0b",
                 i, mon_data[i], mon_ch[i], mon_sof[i], exp_q[i], i / FRAME, i % FRAME == 0);
      end
    end
  endtask

  task automatic test_restart();
    bit ok;
    clear_mon();
    stim.delete();
    ds_ready = 1'b1;
    for (int k = 0; k < 5; k++) add_beat(1'b1, k == 0, rand_word());
    for (int k = 0; k < FRAME; k++) begin
      logic [NUM_CH-1:0][31:0] w;
      for (int c = 0; c < NUM_CH; c++) w[c] = 32'h5000 + 32'h100 * c + k;
      add_beat(1'b1, k == 0, w);
    end
    build_expected();
    drive_stim();
    wait_done(1000, ok);
    n_cmp++;
    if (!ok || done_t.size() != 1) begin
      n_bad++; $display("[TB] FAIL restart_done: got %0d frame_done pulses, required 1", done_t.size());
    end
    n_cmp++;
    if (mon_data.size() != TOTAL) begin
      n_bad++; $display("[TB] FAIL restart_count: got %0d words, required %0d", mon_data.size(), TOTAL);
    end
    for (int i = 0; i < TOTAL && i < mon_data.size(); i++) begin
      n_cmp++;
      if (mon_data[i] !== exp_q[i] || mon_ch[i] != i / FRAME || mon_sof[i] != (i % FRAME == 0)) begin
        n_bad++;
        $display("[TB] FAIL restart_word%0d: got data=%h ch=%0d sof=%0b, required data=%h ch=%0d sof=%0b",
                 i, mon_data[i], mon_ch[i], mon_sof[i], exp_q[i], i / FRAME, i % FRAME == 0);
      end
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++; $display("[TB] FAIL restart_overrun: got %b, required 0", overrun);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    bit seen_dead;
    clear_mon();
    stim.delete();
    ds_ready = 1'b1;
    for (int k = 0; k < FRAME; k++) add_beat(1'b1, k == 0, rand_word());
    build_expected();
    drive_stim();
    for (int n = 0; n < 200 && mon_data.size() < FRAME + 2; n++) @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++; $display("[TB] FAIL overrun_before: got %b, required 0", overrun);
    end
    i_valid = 1'b1;
    i_sof   = 1'b1;
    for (int c = 0; c < NUM_CH; c++) i_data[c] = 32'h0000DEAD;
    @(negedge clk);
    i_valid = 1'b0;
    i_sof   = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++; $display("[TB] FAIL overrun_set: got %b, required 1", overrun);
    end
    wait_done(1000, ok);
    n_cmp++;
    if (!ok || done_t.size() != 1) begin
      n_bad++; $display("[TB] FAIL overrun_done: got %0d frame_done pulses, required 1", done_t.size());
    end
    n_cmp++;
    if (mon_data.size() != TOTAL) begin
      n_bad++; $display("[TB] FAIL overrun_count: got %0d words, required %0d", mon_data.size(), TOTAL);
    end
    seen_dead = 1'b0;
    for (int i = 0; i < TOTAL && i < mon_data.size(); i++) begin
      if (mon_data[i] === 32'h0000DEAD) seen_dead = 1'b1;
      n_cmp++;
      if (mon_data[i] !== exp_q[i] || mon_ch[i] != i / FRAME || mon_sof[i] != (i % FRAME == 0)) begin
        n_bad++;
        $display("[TB] FAIL overrun_word%0d: got data=%h ch=%0d sof=%0b, required data=%h ch=%0d sof=%0b",
                 i, mon_data[i], mon_ch[i], mon_sof[i], exp_q[i], i / FRAME, i % FRAME == 0);
      end
    end
    n_cmp++;
    if (seen_dead) begin
      n_bad++; $display("[TB] FAIL overrun_dead: got 0000dead on o_data, required never");
    end
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++; $display("[TB] FAIL overrun_sticky: got %b, required 1", overrun);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    clear_mon();
    stim.delete();
    ds_ready = 1'b1;
    for (int k = 0; k < FRAME; k++) add_beat(1'b1, k == 0, rand_word());
    drive_stim();
    for (int n = 0; n < 300 && mon_data.size() < 2 * FRAME + 4; n++) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, o_sof, o_data, o_ch, frame_done, overrun, busy} !== '0) begin
      n_bad++;
      $display("[TB] FAIL areset_outputs: got v=%b sof=%b data=%h ch=%0d done=%b ovr=%b busy=%b, required all 0",
               o_valid, o_sof, o_data, o_ch, frame_done, overrun, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    stim.delete();
    for (int j = 0; j < 2; j++) add_beat(1'b1, 1'b0, rand_word());
    for (int k = 0; k < FRAME; k++) add_beat(1'b1, k == 0, rand_word());
    build_expected();
    drive_stim();
    wait_done(1000, ok);
    n_cmp++;
    if (!ok || done_t.size() != 1) begin
      n_bad++; $display("[TB] FAIL areset_done: got %0d frame_done pulses, required 1", done_t.size());
    end
    n_cmp++;
    if (mon_data.size() != TOTAL) begin
      n_bad++; $display("[TB] FAIL areset_count: got %0d words, required %0d", mon_data.size(), TOTAL);
    end
    for (int i = 0; i < TOTAL && i < mon_data.size(); i++) begin
      n_cmp++;
      if (mon_data[i] !== exp_q[i] || mon_ch[i] != i / FRAME || mon_sof[i] != (i % FRAME == 0)) begin
        n_bad++;
        $display("[TB] FAIL areset_word%0d: got data=%h ch=%0d sof=%0b, required data=%h ch=%0d sof=%0b",
                 i, mon_data[i], mon_ch[i], mon_sof[i], exp_q[i], i / FRAME, i % FRAME == 0);
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    i_valid  = 1'b0;
    i_sof    = 1'b0;
    ds_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) i_data[c] = '0;
    $display("[TB] conv_ch_serializer bench start");
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_restart();
    test_overrun();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
